// File: rtl/btb_ras_v2_if.sv
// Lookup/update bundle between fetch, decode/execute and the branch target buffer.
// The master side is the pipeline; the slave side is btb_ras_v2.
interface btb_ras_v2_if #(
   parameter int unsigned IDXW = 5,
   parameter int unsigned RPW  = 3
);
   logic                 fetch_en;
   logic [31:0]          fetch_pc;
   logic                 ret_en;
   logic                 taken;
   logic [31:0]          ret_pc;
   logic [IDXW-1:0]      ret_index;
   logic [1:0]           ret_type;
   logic [2*RPW:0]       ret_ras_snap;
   logic                 operate_en;
   logic [31:0]          operate_pc;
   logic [IDXW-1:0]      operate_index;
   logic [1:0]           operate_type;
   logic                 add_entry;
   logic                 delete_entry;
   logic                 target_error;
   logic                 right_orien;
   logic [31:0]          right_target;
   logic                 push_ras;
   logic                 pop_ras;
   logic                 recover_en;
   logic [2*RPW:0]       recover_snap;

   modport master (
      output fetch_en, fetch_pc,
      output operate_en, operate_pc, operate_index, operate_type,
      output add_entry, delete_entry, target_error, right_orien, right_target,
      output push_ras, pop_ras, recover_en, recover_snap,
      input  ret_en, taken, ret_pc, ret_index, ret_type, ret_ras_snap
   );

   modport slave (
      input  fetch_en, fetch_pc,
      input  operate_en, operate_pc, operate_index, operate_type,
      input  add_entry, delete_entry, target_error, right_orien, right_target,
      input  push_ras, pop_ras, recover_en, recover_snap,
      output ret_en, taken, ret_pc, ret_index, ret_type, ret_ras_snap
   );
endinterface

// File: rtl/btb_ras_v2.sv
// Branch target buffer with per-entry type and a circular, checkpointable return address stack.
// Lookup is registered PC followed by a combinational match against the current array state.
module btb_ras_v2 #(
   parameter int unsigned BTBNUM = 32,
   parameter int unsigned RASNUM = 8,
   parameter int unsigned CNTW   = 2
) (
   input  logic        clk,
   input  logic        reset,
   btb_ras_v2_if.slave bus
);
   localparam int unsigned IDXW = $clog2(BTBNUM);
   localparam int unsigned RPW  = $clog2(RASNUM);
   localparam logic [1:0]      T_COND     = 2'b00;
   localparam logic [1:0]      T_RET      = 2'b10;
   localparam logic [CNTW-1:0] CNT_WEAK_T = {1'b1, {(CNTW-1){1'b0}}};
   localparam logic [CNTW-1:0] CNT_WEAK_N = {1'b0, {(CNTW-1){1'b1}}};
   localparam logic [RPW:0]    RAS_FULL   = (RPW+1)'(RASNUM);

   logic [BTBNUM-1:0] valid_q;
   logic [29:0]       tag_q  [BTBNUM];
   logic [29:0]       tgt_q  [BTBNUM];
   logic [1:0]        type_q [BTBNUM];
   logic [CNTW-1:0]   cnt_q  [BTBNUM];

   logic              fetch_en_r;
   logic [29:0]       fetch_tag_r;
   logic [15:0]       lfsr_q;
   logic              lfsr_fb;

   logic [29:0]       ras_q [RASNUM];
   logic [RPW-1:0]    ptr_q;
   logic [RPW-1:0]    ptr_m1;
   logic [RPW:0]      count_q;
   logic [29:0]       push_data;

   logic              hit_c;
   logic [IDXW-1:0]   hit_idx_c;
   logic [IDXW-1:0]   free_idx_c;
   logic [IDXW-1:0]   alloc_idx;
   logic [IDXW-1:0]   op_idx;
   logic [CNTW-1:0]   cnt_init;
   logic              unused_lsbs;

   assign lfsr_fb     = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
   assign ptr_m1      = ptr_q - RPW'(1);
   assign push_data   = bus.operate_pc[31:2] + 30'd1;
   assign op_idx      = bus.operate_index;
   assign alloc_idx   = (&valid_q) ? lfsr_q[IDXW-1:0] : free_idx_c;
   assign cnt_init    = bus.right_orien ? CNT_WEAK_T : CNT_WEAK_N;
   assign unused_lsbs = ^{bus.fetch_pc[1:0], bus.operate_pc[1:0], bus.right_target[1:0]};

   // Downward scan so the lowest matching / lowest free index wins.
   always_comb begin
      hit_c      = 1'b0;
      hit_idx_c  = '0;
      free_idx_c = '0;
      for (int i = int'(BTBNUM) - 1; i >= 0; i--) begin
         if (fetch_en_r && valid_q[i] && (tag_q[i] == fetch_tag_r)) begin
            hit_c     = 1'b1;
            hit_idx_c = IDXW'(i);
         end
         if (!valid_q[i]) free_idx_c = IDXW'(i);
      end
   end

   always_comb begin
      bus.ret_en       = hit_c;
      bus.taken        = 1'b0;
      bus.ret_pc       = '0;
      bus.ret_index    = '0;
      bus.ret_type     = '0;
      bus.ret_ras_snap = {count_q, ptr_q};
      if (hit_c) begin
         bus.ret_index = hit_idx_c;
         bus.ret_type  = type_q[hit_idx_c];
         case (type_q[hit_idx_c])
            T_COND: begin
               bus.taken  = cnt_q[hit_idx_c][CNTW-1];
               bus.ret_pc = {tgt_q[hit_idx_c], 2'b00};
            end
            T_RET: begin
               if (count_q != '0) begin
                  bus.taken  = 1'b1;
                  bus.ret_pc = {ras_q[ptr_m1], 2'b00};
               end
            end
            default: begin
               bus.taken  = 1'b1;
               bus.ret_pc = {tgt_q[hit_idx_c], 2'b00};
            end
         endcase
      end
   end

   // Fetch register, victim LFSR and entry training.
   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q     <= '0;
         fetch_en_r  <= 1'b0;
         fetch_tag_r <= '0;
         lfsr_q      <= 16'hACE1;
      end else begin
         fetch_en_r <= bus.fetch_en;
         if (bus.fetch_en) fetch_tag_r <= bus.fetch_pc[31:2];
         lfsr_q <= {lfsr_fb, lfsr_q[15:1]};
         if (bus.operate_en) begin
            if (bus.add_entry) begin
               valid_q[alloc_idx] <= 1'b1;
               tag_q[alloc_idx]   <= bus.operate_pc[31:2];
               tgt_q[alloc_idx]   <= bus.right_target[31:2];
               type_q[alloc_idx]  <= bus.operate_type;
               cnt_q[alloc_idx]   <= cnt_init;
            end else if (bus.delete_entry) begin
               valid_q[op_idx] <= 1'b0;
            end else if (bus.target_error) begin
               tgt_q[op_idx] <= bus.right_target[31:2];
               cnt_q[op_idx] <= cnt_init;
            end else if (type_q[op_idx] == T_COND) begin
               if (bus.right_orien && (cnt_q[op_idx] != '1))
                  cnt_q[op_idx] <= cnt_q[op_idx] + CNTW'(1);
               else if (!bus.right_orien && (cnt_q[op_idx] != '0))
                  cnt_q[op_idx] <= cnt_q[op_idx] - CNTW'(1);
            end
         end
      end
   end

   // Return stack: recovery restores pointers only; contents are left as they are.
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q   <= '0;
         count_q <= '0;
      end else if (bus.recover_en) begin
         ptr_q   <= bus.recover_snap[RPW-1:0];
         count_q <= bus.recover_snap[2*RPW:RPW];
      end else if (bus.operate_en) begin
         if (bus.push_ras && bus.pop_ras && (count_q != '0)) begin
            ras_q[ptr_m1] <= push_data;
         end else if (bus.push_ras) begin
            ras_q[ptr_q] <= push_data;
            ptr_q        <= ptr_q + RPW'(1);
            if (count_q != RAS_FULL) count_q <= count_q + (RPW+1)'(1);
         end else if (bus.pop_ras && (count_q != '0)) begin
            ptr_q   <= ptr_m1;
            count_q <= count_q - (RPW+1)'(1);
         end
      end
   end
endmodule

// File: tb/tb_btb_ras_v2.sv
// Directed bench for btb_ras_v2: lookup, training, replacement, return stack and recovery.
module tb_btb_ras_v2;
   localparam int unsigned BTBNUM = 32;
   localparam int unsigned RASNUM = 8;
   localparam int unsigned CNTW   = 2;
   localparam int unsigned IDXW   = 5;
   localparam int unsigned RPW    = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;
   logic [15:0] lfsr_m;

   always #5 clk = ~clk;

   btb_ras_v2_if #(.IDXW(IDXW), .RPW(RPW)) bus ();

   btb_ras_v2 #(.BTBNUM(BTBNUM), .RASNUM(RASNUM), .CNTW(CNTW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Reference LFSR: taps 16,14,13,11, right-shifting Fibonacci form.
   always @(posedge clk) begin
      if (reset) lfsr_m <= 16'hACE1;
      else       lfsr_m <= {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
   end

   // {ret_en, taken, ret_type, ret_index, ret_pc}
   function automatic logic [40:0] vec();
      return {bus.ret_en, bus.taken, bus.ret_type, bus.ret_index, bus.ret_pc};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ops();
      bus.operate_en    = 1'b0;
      bus.operate_pc    = '0;
      bus.operate_index = '0;
      bus.operate_type  = '0;
      bus.add_entry     = 1'b0;
      bus.delete_entry  = 1'b0;
      bus.target_error  = 1'b0;
      bus.right_orien   = 1'b0;
      bus.right_target  = '0;
      bus.push_ras      = 1'b0;
      bus.pop_ras       = 1'b0;
      bus.recover_en    = 1'b0;
      bus.recover_snap  = '0;
   endtask

   task automatic do_reset();
      reset        = 1'b1;
      bus.fetch_en = 1'b0;
      bus.fetch_pc = '0;
      clear_ops();
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic lookup(input logic [31:0] pc);
      bus.fetch_en = 1'b1;
      bus.fetch_pc = pc;
      step();
   endtask

   task automatic op_add(input logic [31:0] pc, input logic [31:0] tgt,
                         input logic [1:0] typ, input logic orien);
      clear_ops();
      bus.operate_en   = 1'b1;
      bus.add_entry    = 1'b1;
      bus.operate_pc   = pc;
      bus.right_target = tgt;
      bus.operate_type = typ;
      bus.right_orien  = orien;
      step();
      clear_ops();
   endtask

   task automatic op_upd(input logic [IDXW-1:0] idx, input logic orien, input logic del,
                         input logic terr, input logic [31:0] tgt);
      clear_ops();
      bus.operate_en    = 1'b1;
      bus.operate_index = idx;
      bus.right_orien   = orien;
      bus.delete_entry  = del;
      bus.target_error  = terr;
      bus.right_target  = tgt;
      step();
      clear_ops();
   endtask

   // operate_index stays 0, which is always a return-type entry during stack tests.
   task automatic op_ras(input logic [31:0] pc, input logic push, input logic pop,
                         input logic rec, input logic [2*RPW:0] snap, input logic oen);
      clear_ops();
      bus.operate_en   = oen;
      bus.operate_pc   = pc;
      bus.push_ras     = push;
      bus.pop_ras      = pop;
      bus.recover_en   = rec;
      bus.recover_snap = snap;
      step();
      clear_ops();
   endtask

   task automatic test_reset();
      logic [40:0] exp;
      do_reset();
      exp = '0;
      checks++; if (vec() !== exp) begin errors++; $display("FAIL reset_out: got %h exp %h", vec(), exp); end
      checks++; if (bus.ret_ras_snap !== 7'h00) begin errors++; $display("FAIL reset_snap: got %h exp 00", bus.ret_ras_snap); end
      lookup(32'h1C00_0000);
      checks++; if (vec() !== exp) begin errors++; $display("FAIL reset_lookup: got %h exp %h", vec(), exp); end
      checks++; if (bus.ret_ras_snap !== 7'h00) begin errors++; $display("FAIL reset_lookup_snap: got %h exp 00", bus.ret_ras_snap); end
   endtask

   task automatic test_cond();
      logic [40:0] exp;
      do_reset();
      op_add(32'h100, 32'h200, 2'b00, 1'b1);
      lookup(32'h100);
      exp = {1'b1, 1'b1, 2'd0, 5'd0, 32'h200};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_hit: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b0, 1'b0, 1'b0, '0);
      op_upd(5'd0, 1'b0, 1'b0, 1'b0, '0);
      exp = {1'b1, 1'b0, 2'd0, 5'd0, 32'h200};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_two_nt: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_sat_low: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b1, 1'b0, 1'b0, '0);
      op_upd(5'd0, 1'b1, 1'b0, 1'b0, '0);
      exp = {1'b1, 1'b1, 2'd0, 5'd0, 32'h200};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_two_t: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b1, 1'b0, 1'b0, '0);
      op_upd(5'd0, 1'b1, 1'b0, 1'b0, '0);
      op_upd(5'd0, 1'b0, 1'b0, 1'b0, '0);
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_sat_high: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b0, 1'b0, 1'b1, 32'h400);
      exp = {1'b1, 1'b0, 2'd0, 5'd0, 32'h400};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_target_err: got %h exp %h", vec(), exp); end
      op_add(32'h104, 32'h500, 2'b01, 1'b0);
      lookup(32'h104);
      exp = {1'b1, 1'b1, 2'd1, 5'd1, 32'h500};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL jump_hit: got %h exp %h", vec(), exp); end
      op_add(32'h108, 32'h600, 2'b00, 1'b0);
      lookup(32'h108);
      exp = {1'b1, 1'b0, 2'd0, 5'd2, 32'h600};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL cond_alloc_nt: got %h exp %h", vec(), exp); end
      op_add(32'h100, 32'h700, 2'b00, 1'b1);
      lookup(32'h100);
      exp = {1'b1, 1'b0, 2'd0, 5'd0, 32'h400};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL multi_lowest: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b0, 1'b1, 1'b0, '0);
      exp = {1'b1, 1'b1, 2'd0, 5'd3, 32'h700};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL delete_next: got %h exp %h", vec(), exp); end
      op_upd(5'd3, 1'b0, 1'b1, 1'b1, 32'h800);
      exp = '0;
      checks++; if (vec() !== exp) begin errors++; $display("FAIL delete_miss: got %h exp %h", vec(), exp); end
   endtask

   task automatic test_replace();
      logic [40:0] exp;
      logic [4:0]  victim;
      logic [4:0]  other;
      do_reset();
      for (int i = 0; i < int'(BTBNUM); i++)
         op_add(32'h8000 + 32'(i) * 4, 32'h9000 + 32'(i) * 4, 2'b01, 1'b1);
      lookup(32'h807C);
      exp = {1'b1, 1'b1, 2'd1, 5'd31, 32'h907C};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL fill_last: got %h exp %h", vec(), exp); end
      victim = lfsr_m[4:0];
      other  = victim + 5'd1;
      op_add(32'hA000, 32'hB000, 2'b01, 1'b1);
      lookup(32'hA000);
      exp = {1'b1, 1'b1, 2'd1, victim, 32'hB000};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL victim_hit: got %h exp %h", vec(), exp); end
      lookup(32'h8000 + 32'(victim) * 4);
      exp = '0;
      checks++; if (vec() !== exp) begin errors++; $display("FAIL victim_old_miss: got %h exp %h", vec(), exp); end
      lookup(32'h8000 + 32'(other) * 4);
      exp = {1'b1, 1'b1, 2'd1, other, 32'h9000 + 32'(other) * 4};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL other_kept: got %h exp %h", vec(), exp); end
   endtask

   task automatic test_ras();
      logic [40:0] exp;
      do_reset();
      op_add(32'h2000, 32'h0, 2'b10, 1'b1);
      lookup(32'h2000);
      exp = {1'b1, 1'b0, 2'd2, 5'd0, 32'h0};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL ras_empty: got %h exp %h", vec(), exp); end
      for (int k = 0; k < 9; k++) op_ras(32'h1000 + 32'(k) * 4, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      checks++; if (bus.ret_ras_snap !== 7'h41) begin errors++; $display("FAIL ras_full_snap: got %h exp 41", bus.ret_ras_snap); end
      for (int k = 0; k < 8; k++) begin
         exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h1024 - 32'(k) * 4};
         checks++; if (vec() !== exp) begin errors++; $display("FAIL ras_pop%0d: got %h exp %h", k, vec(), exp); end
         op_ras(32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      end
      exp = {1'b1, 1'b0, 2'd2, 5'd0, 32'h0};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL ras_drained: got %h exp %h", vec(), exp); end
      op_ras(32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      checks++; if (bus.ret_ras_snap !== 7'h01) begin errors++; $display("FAIL ras_underflow_snap: got %h exp 01", bus.ret_ras_snap); end
      checks++; if (vec() !== exp) begin errors++; $display("FAIL ras_underflow: got %h exp %h", vec(), exp); end
   endtask

   task automatic test_recover();
      logic [40:0]    exp;
      logic [2*RPW:0] snap;
      do_reset();
      op_add(32'h2000, 32'h0, 2'b10, 1'b1);
      lookup(32'h2000);
      op_ras(32'h3000, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      op_ras(32'h3004, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      snap = bus.ret_ras_snap;
      checks++; if (snap !== 7'h12) begin errors++; $display("FAIL rec_capture: got %h exp 12", snap); end
      for (int k = 0; k < 3; k++) op_ras(32'h3008 + 32'(k) * 4, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h3014};
      checks++; if (bus.ret_ras_snap !== 7'h2D) begin errors++; $display("FAIL rec_pushed_snap: got %h exp 2d", bus.ret_ras_snap); end
      checks++; if (vec() !== exp) begin errors++; $display("FAIL rec_pushed_top: got %h exp %h", vec(), exp); end
      op_ras(32'h7000, 1'b1, 1'b0, 1'b1, snap, 1'b1);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h3008};
      checks++; if (bus.ret_ras_snap !== 7'h12) begin errors++; $display("FAIL rec_snap: got %h exp 12", bus.ret_ras_snap); end
      checks++; if (vec() !== exp) begin errors++; $display("FAIL rec_top: got %h exp %h", vec(), exp); end
      op_ras(32'h7100, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      checks++; if (bus.ret_ras_snap !== 7'h12) begin errors++; $display("FAIL no_operate_en: got %h exp 12", bus.ret_ras_snap); end
      op_ras(32'h0, 1'b0, 1'b0, 1'b1, 7'h2D, 1'b0);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h3014};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL rec_no_oen: got %h exp %h", vec(), exp); end
   endtask

   task automatic test_push_pop();
      logic [40:0] exp;
      do_reset();
      op_add(32'h2000, 32'h0, 2'b10, 1'b1);
      lookup(32'h2000);
      op_ras(32'h3000, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      op_ras(32'h300, 1'b1, 1'b1, 1'b0, '0, 1'b1);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h304};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL pushpop_top: got %h exp %h", vec(), exp); end
      checks++; if (bus.ret_ras_snap !== 7'h09) begin errors++; $display("FAIL pushpop_snap: got %h exp 09", bus.ret_ras_snap); end
      op_ras(32'h0, 1'b0, 1'b1, 1'b0, '0, 1'b1);
      op_ras(32'h400, 1'b1, 1'b1, 1'b0, '0, 1'b1);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h404};
      checks++; if (bus.ret_ras_snap !== 7'h09) begin errors++; $display("FAIL pushpop_empty_snap: got %h exp 09", bus.ret_ras_snap); end
      checks++; if (vec() !== exp) begin errors++; $display("FAIL pushpop_empty_top: got %h exp %h", vec(), exp); end
      op_ras(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, '0, 1'b1);
      exp = {1'b1, 1'b1, 2'd2, 5'd0, 32'h0};
      checks++; if (vec() !== exp) begin errors++; $display("FAIL push_wrap: got %h exp %h", vec(), exp); end
      op_upd(5'd0, 1'b0, 1'b1, 1'b0, '0);
      exp = '0;
      checks++; if (vec() !== exp) begin errors++; $display("FAIL ret_delete: got %h exp %h", vec(), exp); end
   endtask

   task automatic test_reset_priority();
      logic [40:0] exp;
      clear_ops();
      reset             = 1'b1;
      bus.operate_en    = 1'b1;
      bus.add_entry     = 1'b1;
      bus.operate_pc    = 32'h5000;
      bus.right_target  = 32'h6000;
      bus.operate_type  = 2'b01;
      bus.push_ras      = 1'b1;
      bus.recover_en    = 1'b1;
      bus.recover_snap  = 7'h2D;
      step();
      reset = 1'b0;
      clear_ops();
      checks++; if (bus.ret_ras_snap !== 7'h00) begin errors++; $display("FAIL rst_prio_snap: got %h exp 00", bus.ret_ras_snap); end
      lookup(32'h5000);
      exp = '0;
      checks++; if (vec() !== exp) begin errors++; $display("FAIL rst_prio_alloc: got %h exp %h", vec(), exp); end
   endtask

   initial begin
      test_reset();
      test_cond();
      test_replace();
      test_ras();
      test_recover();
      test_push_pop();
      test_reset_priority();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/btb_ras_v2.md
# btb_ras_v2

Parametrised branch target buffer with an integrated, checkpointable return address stack, sitting between instruction fetch (IF) and decode (ID). IF presents a fetch PC; one cycle later the block reports hit, direction, target and a RAS snapshot. ID/EX trains entries, drives push/pop, and restores the RAS pointer on a redirect. Compared with the previous generation it adds:

- per-entry branch type instead of a separate RAS tag table;
- a circular, overwrite-on-full RAS with checkpoint recovery;
- configurable depth and counter width.

## Interface
- BTBNUM, 32: BTB entries; power of two, 4..65536; IDXW = log2(BTBNUM) derived locally
- RASNUM, 8: RAS entries; power of two, 2..256; RPW = log2(RASNUM) derived locally
- CNTW, 2: direction counter width, 2..4
- clk  input  1  single clock, all state on rising edge
- reset  input  1  synchronous, active-high
- fetch_en  input  1  lookup request
- fetch_pc  input  32  lookup PC
- ret_en  output  1  BTB hit for registered lookup
- taken  output  1  predicted taken
- ret_pc  output  32  predicted target, {target,2'b0}; 0 when !ret_en
- ret_index  output  IDXW  hit entry index; 0 when !ret_en
- ret_type  output  2  hit entry type; 0 when !ret_en
- ret_ras_snap  output  RPW+RPW+1  {count, ptr} of RAS at lookup evaluation
- operate_en  input  1  update strobe
- operate_pc  input  32  PC of resolved instruction
- operate_index  input  IDXW  entry index returned at its lookup
- operate_type  input  2  00 conditional, 01 direct jump/call, 10 return, 11 indirect
- add_entry  input  1  allocate new entry (instruction missed at lookup)
- delete_entry  input  1  invalidate operate_index
- target_error  input  1  rewrite target of operate_index
- right_orien  input  1  actual direction
- right_target  input  32  actual target
- push_ras  input  1  push operate_pc+4 (call)
- pop_ras  input  1  pop (return)
- recover_en  input  1  restore RAS from recover_snap
- recover_snap  input  RPW+RPW+1  snapshot previously from ret_ras_snap

## Operation
- Storage per entry:
  - valid;
  - tag = pc[31:2];
  - target[31:2];
  - type[1:0];
  - counter[CNTW-1:0].
- Lookup: fetch_pc and fetch_en are registered when fetch_en = 1 (fetch_en_r always follows fetch_en). Match = fetch_en_r & valid & tag == fetch_pc_r[31:2]. Multiple matches resolve to the lowest index.
- Per type on hit:
  - 00: taken = counter MSB, ret_pc from table.
  - 01 and 11: taken = 1, ret_pc from table.
  - 10: ret_pc = {RAS top, 2'b0}; taken = 1 if RAS count > 0, else 0 with ret_pc = 0.
- Allocation (operate_en & add_entry): choose the lowest-index invalid entry. If all entries are valid, choose LFSR[IDXW-1:0]. Write valid = 1, tag, target, type. Counter is set to 2^(CNTW-1) if right_orien, else 2^(CNTW-1)-1.
- Maintenance (operate_en & !add_entry), priority order:
  1. delete_entry clears valid.
  2. Otherwise target_error writes target and resets the counter as on allocation.
  3. Otherwise, for a type-00 entry only, the counter saturates up on right_orien and down otherwise.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, reset 16'hACE1. Advances every cycle. For IDXW = 16 it uses all 16 bits.
- RAS: circular array with ptr (next write slot, wraps modulo RASNUM) and count (0..RASNUM). Top = entry[ptr-1 mod RASNUM]. Updates take effect only when operate_en = 1, except recovery; priority order:
  1. recover_en (independent of operate_en): ptr and count are loaded from recover_snap; push/pop in the same cycle are ignored. Stack contents are not restored.
  2. push & pop together: write operate_pc[31:2]+1 at ptr-1; ptr and count unchanged; if count = 0, this behaves as a plain push.
  3. push: write at ptr, ptr+1. count+1, saturating at RASNUM; when full, this overwrites the oldest entry.
  4. pop: if count > 0, ptr-1 and count-1; otherwise no change.
- Push data arithmetic is 30-bit, modulo 2^30.

## Timing
- Lookup latency is one cycle. Lookup outputs are combinational from fetch_pc_r/fetch_en_r and current array state.
- Any write at edge E is visible to lookup outputs from E onward; there is no bypass of same-edge writes.
- ret_ras_snap reflects the RAS state in the cycle the outputs are valid.
- After reset: valid = 0, ptr = 0, count = 0, fetch_en_r = 0. All outputs are 0, except that ret_ras_snap = 0 and taken = 0.
- Reset asserted mid-operation discards concurrent updates and recoveries. Reset has priority over everything.
- Updates with operate_en = 0 are ignored entirely. Flags other than those listed under priority are don't-care.

## Test plan
- Reset, then fetch_en with pc 0x1C000000 -> next cycle ret_en = 0, taken = 0, ret_pc = 0, ret_ras_snap = 0.
- Add type 00 at pc 0x100, target 0x200, right_orien = 1. Fetch 0x100 -> ret_en = 1, taken = 1, ret_pc = 0x200, ret_index = 0. Apply two not-taken updates (CNTW = 2) -> taken = 0.
- Fill all BTBNUM entries, add one more -> victim index equals LFSR[IDXW-1:0] at that edge. The victim's old pc misses afterward.
- Push 9 calls from pc 0x1000, 0x1004, … with RASNUM = 8 -> count = 8. A type-10 hit predicts 0x1024; eight pops follow the stack order down to 0x1008; a ninth pop leaves count = 0 and taken = 0.
- Capture ret_ras_snap, push 3 entries, then apply recover_en with the snapshot together with push_ras -> ptr and count equal the snapshot and the push is ignored.
- push & pop in the same cycle with operate_pc 0x300 -> top becomes 0x304 and count is unchanged. delete_entry on a hit index -> next lookup misses.
